// File: rtl/adder_seq_arbiter_if.sv
// rtl/adder_seq_arbiter_if.sv - nibble bus between the sequencer and the shared 4-bit adder chain
interface adder_seq_arbiter_if;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [3:0] add_sum;
  logic       add_cout;

  modport master (
    output add_a,
    output add_b,
    output add_cin,
    input  add_sum,
    input  add_cout
  );

  modport slave (
    input  add_a,
    input  add_b,
    input  add_cin,
    output add_sum,
    output add_cout
  );
endinterface

// File: rtl/adder_seq_arbiter.sv
// rtl/adder_seq_arbiter.sv - round-robin two-client nibble-serial adder over a shared 4-bit adder; ADD_SEQ_SUB_EN adds subtract
module adder_seq_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
`ifdef ADD_SEQ_SUB_EN
  input  logic             sub0,
  input  logic             sub1,
`endif
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             owner,
  output logic             busy,
  adder_seq_arbiter_if.master add
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             rr;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             grant;
  logic             sub_sel;
  logic             last;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;

  // A lone requester wins outright; a tie goes to the round-robin pointer.
  always_comb begin
    grant = rr;
    if (req0 && !req1) grant = 1'b0;
    else if (req1 && !req0) grant = 1'b1;
  end

`ifdef ADD_SEQ_SUB_EN
  assign sub_sel = grant ? sub1 : sub0;
`else
  assign sub_sel = 1'b0;
`endif

  assign sh_a = op_a >> (4 * idx);
  assign sh_b = op_b >> (4 * idx);
  assign last = (int'(idx) == NIB - 1);
  assign busy = (state != IDLE);

  always_comb begin
    add.add_a   = 4'h0;
    add.add_b   = 4'h0;
    add.add_cin = 1'b0;
    if (state == RUN) begin
      add.add_a   = sh_a[3:0];
      add.add_b   = sh_b[3:0] ^ {4{op_sub}};
      add.add_cin = carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr     <= 1'b0;
      idx    <= '0;
      carry  <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_sub <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      owner  <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner  <= grant;
            op_a   <= grant ? a1 : a0;
            op_b   <= grant ? b1 : b0;
            op_sub <= sub_sel;
            idx    <= '0;
            // Subtract is A + ~B + 1, so the chain starts with carry set.
            carry  <= sub_sel;
            state  <= RUN;
          end
        end
        RUN: begin
          for (int n = 0; n < NIB; n++) begin
            if (int'(idx) == n) result[4*n +: 4] <= add.add_sum;
          end
          carry <= add.add_cout;
          idx   <= idx + 1'b1;
          if (last) begin
            cout  <= add.add_cout;
            done0 <= ~owner;
            done1 <= owner;
            state <= DONE;
          end
        end
        DONE: begin
          rr    <= ~owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_arbiter.sv
// tb/tb_adder_seq_arbiter.sv - scoreboard bench for adder_seq_arbiter with a behavioural shared adder
module tb_adder_seq_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] a0 = '0;
  logic [7:0] b0 = '0;
  logic [7:0] a1 = '0;
  logic [7:0] b1 = '0;
`ifdef ADD_SEQ_SUB_EN
  logic       sub0 = 1'b0;
  logic       sub1 = 1'b0;
`endif
  logic       done0;
  logic       done1;
  logic [7:0] result;
  logic       cout;
  logic       owner;
  logic       busy;

  adder_seq_arbiter_if bus ();

  logic [4:0] adder_s;
  assign adder_s      = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0, bus.add_cin};
  assign bus.add_sum  = adder_s[3:0];
  assign bus.add_cout = adder_s[4];

  adder_seq_arbiter #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .a0     (a0),
    .b0     (b0),
    .req1   (req1),
    .a1     (a1),
    .b1     (b1),
`ifdef ADD_SEQ_SUB_EN
    .sub0   (sub0),
    .sub1   (sub1),
`endif
    .done0  (done0),
    .done1  (done1),
    .result (result),
    .cout   (cout),
    .owner  (owner),
    .busy   (busy),
    .add    (bus)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] cyc    = '0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        cl;
    logic [7:0]  res;
    logic        co;
    logic [31:0] at;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push_exp(input logic cl, input logic [7:0] res, input logic co, input logic [31:0] at);
    exp_t e;
    e.cl  = cl;
    e.res = res;
    e.co  = co;
    e.at  = at;
    sb.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_result"}, 64'(result), 64'h0);
    chk({tag, "_ctl"}, 64'({cout, owner, busy, done0, done1}), 64'h0);
    chk({tag, "_bus"}, 64'({bus.add_a, bus.add_b, bus.add_cin}), 64'h0);
  endtask

  task automatic chk_bus(input string tag, input logic [3:0] ea, input logic [3:0] eb, input logic ec);
    chk(tag, 64'({bus.add_a, bus.add_b, bus.add_cin}), 64'({ea, eb, ec}));
  endtask

  // Monitor: every done pulse pops one expectation (client, sum, carry, cycle).
  always @(negedge clk) begin
    if (!rst && (done0 || done1)) begin
      exp_t e;
      if (done0 && done1) begin
        chk("done_both", 64'({done0, done1}), 64'b10);
      end else if (sb.size() == 0) begin
        chk("unexpected_done", 64'({done0, done1}), 64'b00);
      end else begin
        e = sb.pop_front();
        chk("done_result", 64'({done1, result, cout, cyc}), 64'({e.cl, e.res, e.co, e.at}));
      end
    end
  end

  logic [31:0] t0;

  initial begin
    // reset held, then released with no traffic
    repeat (3) @(negedge clk);
    chk_all_zero("rst_hold");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("post_rst");

    // 0x3C + 0x55 = 0x91
    t0 = cyc;
    req0 = 1'b1; a0 = 8'h3C; b0 = 8'h55;
    push_exp(1'b0, 8'h91, 1'b0, t0 + 3);
    @(negedge clk);
    req0 = 1'b0; a0 = 8'hAA; b0 = 8'hAA;
    chk_bus("add_c1_3c55", 4'hC, 4'h5, 1'b0);
    chk("busy_run", 64'({busy, owner}), 64'b10);
    @(negedge clk);
    chk_bus("add_c2_3c55", 4'h3, 4'h5, 1'b1);
    @(negedge clk);
    chk("owner_done", 64'(owner), 64'h0);
    @(negedge clk);
    chk("hold_idle", 64'({result, cout, busy}), 64'({8'h91, 1'b0, 1'b0}));

    // 0xFF + 0x01 wraps to 0x00 with carry out
    t0 = cyc;
    req0 = 1'b1; a0 = 8'hFF; b0 = 8'h01;
    push_exp(1'b0, 8'h00, 1'b1, t0 + 3);
    @(negedge clk);
    req0 = 1'b0;
    chk_bus("add_c1_ff01", 4'hF, 4'h1, 1'b0);
    @(negedge clk);
    chk_bus("add_c2_ff01", 4'hF, 4'h0, 1'b1);
    repeat (2) @(negedge clk);

    // simultaneous requests after reset, held through a third grant
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    t0 = cyc;
    req0 = 1'b1; a0 = 8'h10; b0 = 8'h20;
    req1 = 1'b1; a1 = 8'h80; b1 = 8'h90;
    push_exp(1'b0, 8'h30, 1'b0, t0 + 3);
    push_exp(1'b1, 8'h10, 1'b1, t0 + 7);
    push_exp(1'b0, 8'h30, 1'b0, t0 + 11);
    repeat (5) @(negedge clk);
    chk("owner_client1", 64'({owner, busy}), 64'b11);
    repeat (4) @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_rr", 64'(busy), 64'h0);

    // reset mid-operation aborts client 1 with no done pulse
    req1 = 1'b1; a1 = 8'h44; b1 = 8'h11;
    @(negedge clk);
    req1 = 1'b0;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid_run");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    t0 = cyc;
    req0 = 1'b1; a0 = 8'h01; b0 = 8'h02;
    push_exp(1'b0, 8'h03, 1'b0, t0 + 3);
    @(negedge clk);
    req0 = 1'b0;
    repeat (4) @(negedge clk);

`ifdef ADD_SEQ_SUB_EN
    t0 = cyc;
    req0 = 1'b1; sub0 = 1'b1; a0 = 8'h05; b0 = 8'h07;
    push_exp(1'b0, 8'hFE, 1'b0, t0 + 3);
    @(negedge clk);
    req0 = 1'b0;
    chk_bus("sub_c1", 4'h5, 4'h8, 1'b1);
    repeat (3) @(negedge clk);
    t0 = cyc;
    req0 = 1'b1; a0 = 8'h07; b0 = 8'h05;
    push_exp(1'b0, 8'h02, 1'b1, t0 + 3);
    @(negedge clk);
    req0 = 1'b0;
    repeat (4) @(negedge clk);
    sub0 = 1'b0;
`endif

    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
